// File: rtl/riscv_alu.sv
// RV32IM execute-stage ALU with a registered result and zero flag.
// Every operation, including multiply and divide, completes in a single cycle.
// The result is captured on each rising edge and has a latency of one clock.
module riscv_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      ALU_Ctrl,
    input  logic            Bsel,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] Imm,
    output logic [XLEN-1:0] ALU_Out,
    output logic            zero
);

    localparam logic [4:0] OpAdd    = 5'b00000;
    localparam logic [4:0] OpSub    = 5'b00001;
    localparam logic [4:0] OpSll    = 5'b00010;
    localparam logic [4:0] OpSlt    = 5'b00011;
    localparam logic [4:0] OpSltu   = 5'b00100;
    localparam logic [4:0] OpXor    = 5'b00101;
    localparam logic [4:0] OpSrl    = 5'b00110;
    localparam logic [4:0] OpSra    = 5'b00111;
    localparam logic [4:0] OpOr     = 5'b01000;
    localparam logic [4:0] OpAnd    = 5'b01001;
    localparam logic [4:0] OpPass   = 5'b01010;
    localparam logic [4:0] OpJalr   = 5'b01011;
    localparam logic [4:0] OpMul    = 5'b10000;
    localparam logic [4:0] OpMulh   = 5'b10001;
    localparam logic [4:0] OpMulhsu = 5'b10010;
    localparam logic [4:0] OpMulhu  = 5'b10011;
    localparam logic [4:0] OpDiv    = 5'b10100;
    localparam logic [4:0] OpDivu   = 5'b10101;
    localparam logic [4:0] OpRem    = 5'b10110;
    localparam logic [4:0] OpRemu   = 5'b10111;

    localparam logic [XLEN-1:0] One = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]   op2;
    logic [4:0]        shamt;
    logic              a_signed;
    logic              b_signed;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic              div_by_zero;
    logic [XLEN-1:0]   divisor_u;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   quot_u;
    logic [XLEN-1:0]   rem_u;
    logic [XLEN-1:0]   result;

    // Operand select plus the shared multiplier and divider datapaths
    always_comb begin
        op2   = Bsel ? Imm : B;
        shamt = op2[4:0];

        // One 64-bit product serves all four multiply ops; only the operand
        // extension changes. The low half is identical for every extension.
        a_signed = (ALU_Ctrl == OpMulh) || (ALU_Ctrl == OpMulhsu);
        b_signed = (ALU_Ctrl == OpMulh);
        mul_a    = {{XLEN{A[XLEN-1] & a_signed}}, A};
        mul_b    = {{XLEN{op2[XLEN-1] & b_signed}}, op2};
        prod     = mul_a * mul_b;

        // Divisor forced to 1 when zero so the divider never sees /0; the
        // architectural divide-by-zero results are substituted later.
        div_by_zero = (op2 == '0);
        divisor_u   = div_by_zero ? One : op2;
        quot_u      = A / divisor_u;
        rem_u       = A % divisor_u;

        // Signed divide on magnitudes. The overflow case (-2^31 / -1) falls out
        // naturally: magnitude 2^31 with matching signs stays 0x80000000, rem 0.
        a_mag  = A[XLEN-1] ? (~A + One) : A;
        b_mag  = divisor_u[XLEN-1] ? (~divisor_u + One) : divisor_u;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        quot_s = (A[XLEN-1] ^ op2[XLEN-1]) ? (~q_mag + One) : q_mag;
        rem_s  = A[XLEN-1] ? (~r_mag + One) : r_mag;
    end

    // Operation decode; unassigned codes yield zero
    always_comb begin
        result = '0;
        case (ALU_Ctrl)
            OpAdd:    result = A + op2;
            OpSub:    result = A - op2;
            OpSll:    result = A << shamt;
            OpSlt:    result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(op2))};
            OpSltu:   result = {{(XLEN-1){1'b0}}, (A < op2)};
            OpXor:    result = A ^ op2;
            OpSrl:    result = A >> shamt;
            OpSra:    result = $unsigned($signed(A) >>> shamt);
            OpOr:     result = A | op2;
            OpAnd:    result = A & op2;
            OpPass:   result = op2;
            OpJalr:   result = (A + op2) & ~One;
            OpMul:    result = prod[XLEN-1:0];
            OpMulh:   result = prod[2*XLEN-1:XLEN];
            OpMulhsu: result = prod[2*XLEN-1:XLEN];
            OpMulhu:  result = prod[2*XLEN-1:XLEN];
            OpDiv:    result = div_by_zero ? '1 : quot_s;
            OpDivu:   result = div_by_zero ? '1 : quot_u;
            OpRem:    result = div_by_zero ? A : rem_s;
            OpRemu:   result = div_by_zero ? A : rem_u;
            default:  result = '0;
        endcase
    end

    // Output register; zero is derived from the same result so it always tracks ALU_Out
    always_ff @(posedge clock) begin
        if (reset) begin
            ALU_Out <= '0;
            zero    <= 1'b1;
        end else begin
            ALU_Out <= result;
            zero    <= (result == '0);
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: a behavioural model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_riscv_alu;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ALU_Ctrl;
    logic        Bsel;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Imm;
    logic [31:0] ALU_Out;
    logic        zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_out;
    logic        exp_valid = 1'b0;

    riscv_alu #(.XLEN(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .ALU_Ctrl (ALU_Ctrl),
        .Bsel     (Bsel),
        .A        (A),
        .B        (B),
        .Imm      (Imm),
        .ALU_Out  (ALU_Out),
        .zero     (zero)
    );

    always #5 clock = ~clock;

    // Reference model using 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] o);
        longint      sa;
        longint      so;
        longint      ua;
        longint      uo;
        longint      p;
        logic [63:0] pv;
        int          sh;
        sa = longint'($signed(a));
        so = longint'($signed(o));
        ua = longint'({32'b0, a});
        uo = longint'({32'b0, o});
        sh = int'(o & 32'd31);
        p  = 0;
        case (c)
            5'd0:  p = ua + uo;
            5'd1:  p = ua - uo;
            5'd2:  p = ua << sh;
            5'd3:  p = (sa < so) ? 1 : 0;
            5'd4:  p = (ua < uo) ? 1 : 0;
            5'd5:  p = ua ^ uo;
            5'd6:  p = ua >> sh;
            5'd7:  p = sa >>> sh;
            5'd8:  p = ua | uo;
            5'd9:  p = ua & uo;
            5'd10: p = uo;
            5'd11: p = (ua + uo) & ~longint'(1);
            5'd16: p = ua * uo;
            5'd17: p = (sa * so) >>> 32;
            5'd18: p = (sa * uo) >>> 32;
            5'd19: p = (ua * uo) >> 32;
            5'd20: p = (o == 0) ? -1 : sa / so;
            5'd21: p = (o == 0) ? -1 : ua / uo;
            5'd22: p = (o == 0) ? sa : sa % so;
            5'd23: p = (o == 0) ? ua : ua % uo;
            default: p = 0;
        endcase
        pv = p;
        return pv[31:0];
    endfunction

    // Model tracks what the DUT should capture at each rising edge
    always @(posedge clock) begin
        exp_out   <= reset ? 32'h0 : model(ALU_Ctrl, A, Bsel ? Imm : B);
        exp_valid <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (exp_valid) begin
            checks++;
            if (ALU_Out !== exp_out || zero !== (exp_out == 32'h0)) begin
                errors++;
                $display("FAIL model t=%0t out=%h zero=%b required out=%h zero=%b",
                         $time, ALU_Out, zero, exp_out, (exp_out == 32'h0));
            end
        end
    end

    // Drive one vector, let one edge pass, then compare to a literal
    task automatic vec(input string nm, input logic [4:0] c, input logic bs,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] expv);
        ALU_Ctrl = c;
        Bsel     = bs;
        A        = a;
        B        = b;
        Imm      = imm;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ALU_Out !== expv || zero !== (expv == 32'h0)) begin
            errors++;
            $display("FAIL %s out=%h zero=%b required out=%h zero=%b",
                     nm, ALU_Out, zero, expv, (expv == 32'h0));
        end
    endtask

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL pin_%s model=%h required=%h", nm, got, expv);
        end
    endtask

    initial begin
        logic [31:0] sweep_a [3];
        logic [31:0] sweep_o [3];
        sweep_a = '{32'h80000000, 32'hDEADBEEF, 32'h00000007};
        sweep_o = '{32'hFFFFFFFF, 32'h00000013, 32'h00000000};

        // Model pins against hand-computed values
        pin("mulhsu", model(5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        pin("div_ovf", model(5'b10100, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
        pin("rem_neg", model(5'b10110, 32'hFFFFFFF9, 32'h00000002), 32'hFFFFFFFF);
        pin("sra", model(5'b00111, 32'h80000000, 32'h00000024), 32'hF8000000);

        // Reset held two clocks with an ADD pending
        reset    = 1'b1;
        ALU_Ctrl = 5'b00000;
        Bsel     = 1'b0;
        A        = 32'd5;
        B        = 32'd3;
        Imm      = 32'd0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ALU_Out !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset out=%h zero=%b required out=00000000 zero=1", ALU_Out, zero);
        end
        reset = 1'b0;

        vec("add_after_reset", 5'b00000, 1'b0, 32'd5, 32'd3, 32'd0, 32'd8);
        vec("sub_zero", 5'b00001, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
        vec("slt", 5'b00011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1);
        vec("sltu", 5'b00100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        vec("sra", 5'b00111, 1'b1, 32'h80000000, 32'd0, 32'h24, 32'hF8000000);
        vec("srl", 5'b00110, 1'b1, 32'h80000000, 32'd0, 32'h24, 32'h08000000);
        vec("sll", 5'b00010, 1'b0, 32'h00000003, 32'd31, 32'd0, 32'h80000000);
        vec("jalr", 5'b01011, 1'b1, 32'h1001, 32'd0, 32'd2, 32'h1002);
        vec("mulh", 5'b10001, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0);
        vec("mulhu", 5'b10011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE);
        vec("mul", 5'b10000, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h1);
        vec("mulhsu", 5'b10010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF);
        vec("div_by0", 5'b10100, 1'b0, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF);
        vec("divu_by0", 5'b10101, 1'b0, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF);
        vec("remu_by0", 5'b10111, 1'b0, 32'd7, 32'd0, 32'd0, 32'd7);
        vec("rem_by0", 5'b10110, 1'b0, 32'hFFFFFFF9, 32'd0, 32'd0, 32'hFFFFFFF9);
        vec("div_ovf", 5'b10100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        vec("rem_ovf", 5'b10110, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h0);
        vec("div_neg", 5'b10100, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFD);
        vec("rem_neg", 5'b10110, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFF);
        vec("divu", 5'b10101, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'h7FFFFFFC);

        // Back-to-back code changes, one per cycle
        vec("b2b_add", 5'b00000, 1'b0, 32'd5, 32'd3, 32'd0, 32'd8);
        vec("b2b_xor", 5'b00101, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'd0, 32'h0000FF00);
        vec("b2b_bad", 5'b11111, 1'b0, 32'hFFFFFFFF, 32'h1, 32'd0, 32'h0);
        vec("b2b_pass", 5'b01010, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h12345000, 32'h12345000);

        // Every code against a few boundary operand pairs, checked by the model
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 32; c++) begin
                ALU_Ctrl = 5'(c);
                A        = sweep_a[p];
                Bsel     = p[0];
                B        = p[0] ? 32'h5A5A5A5A : sweep_o[p];
                Imm      = p[0] ? sweep_o[p] : 32'hA5A5A5A5;
                @(negedge clock);
            end
        end

        // Reset mid-stream overrides a nonzero result
        reset    = 1'b1;
        ALU_Ctrl = 5'b00000;
        A        = 32'd1;
        B        = 32'd1;
        Bsel     = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ALU_Out !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid out=%h zero=%b required out=00000000 zero=1", ALU_Out, zero);
        end
        reset = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
